kbd_input_ctrl: RTL and testbench
=================================

// Module: kbd_input_ctrl
// PURPOSE
//  Keyboard front end for the eLC-3 memory-mapped I/O path. Debounces a raw pushbutton
//  ("Enter" key) and, on each confirmed press, captures the synchronized 16-bit switch
//  value into KBDR and raises the KBSR ready bit. Sits directly upstream of the memory
//  control unit, which presents KBDR/KBSR to the CPU and pulses Rd_KBDR when the CPU
//  reads KBDR. Replaces the free-running switch feed with a one-character-per-press handshake.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable cycles to accept a level change (10 ms @ 50 MHz); >= 1
//  DATA_W           16      width of switch data / KBDR
// PORTS
//  Clk       in   1       system clock (CLOCK_50); all state changes on rising edge
//  Reset_n   in   1       synchronous, active-low reset
//  Key_n     in   1       raw pushbutton, asynchronous, active-low (0 = pressed)
//  Switches  in   DATA_W  switch value, already synchronized to Clk
//  Rd_KBDR   in   1       one-cycle pulse from memory control: CPU read KBDR this cycle
//  KBDR      out  DATA_W  captured keyboard data
//  KBSR      out  16      {ready, overrun, 14'b0}
//  Pressed   out  1       debounced key level (1 = held); status/LED use only
// BEHAVIOUR
//  Reset (Reset_n == 0 at an edge): KBDR = 0, KBSR = 0, Pressed = 0, FSM = IDLE, counter = 0,
//    sync flops = 1 (released). This applies mid-debounce and mid-press; a key still held
//    after reset is released must pass through a full debounce again before any capture.
//  Sync: 2-flop synchronizer on Key_n; "key" = ~sync2. Only "key" feeds the FSM.
//  Counter: $clog2(DEBOUNCE_CYCLES+1) bits, saturates at DEBOUNCE_CYCLES (never wraps).
//  FSM (Pressed = 1 in PRESSED and DEB_REL):
//   IDLE:     key=1 -> DEB_PRS, cnt=1; else stay.
//   DEB_PRS:  key=0 -> IDLE (bounce, no capture); cnt==DEBOUNCE_CYCLES -> PRESSED + CAPTURE;
//             else cnt++.
//   PRESSED:  key=0 -> DEB_REL, cnt=1; else stay (holding the key never re-captures).
//   DEB_REL:  key=1 -> PRESSED (bounce, no capture); cnt==DEBOUNCE_CYCLES -> IDLE; else cnt++.
//  Latency: with Key_n low from edge 0 and held, ready and KBDR are visible after edge
//    DEBOUNCE_CYCLES+3. Switches are sampled at that same capture edge.
//  CAPTURE, ready==0: KBDR <= Switches, ready <= 1.
//  CAPTURE, ready==1 with no Rd_KBDR that cycle: KBDR is held (new data dropped), overrun <= 1.
//  Rd_KBDR alone: ready <= 0 and overrun <= 0 at the next edge. KBDR is held.
//  CAPTURE and Rd_KBDR in the same cycle: capture wins. KBDR <= Switches, ready <= 1, overrun <= 0.
//  Rd_KBDR while ready==0: no effect. Overrun is sticky until the next Rd_KBDR or reset.
//  KBSR[13:0] are always 0. All outputs are registered. Nothing is combinational from the inputs.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1. Reset_n=0 for 2 edges, Key_n=1 -> KBDR=0, KBSR=16'h0000, Pressed=0. Reset is ignored
//     until an edge is sampled.
//  2. Switches=16'h0041, Key_n low from edge 0 and held -> KBSR=16'h8000 and KBDR=16'h0041
//     after edge 7, not before. Pulse Rd_KBDR -> KBSR=16'h0000 after the next edge.
//  3. Key_n toggled low 3 cycles, high 1 cycle, repeated 5 times, then high -> no capture,
//     KBSR stays 16'h0000.
//  4. Press capturing 16'h0041 with no read, release, then press with Switches=16'h0042 ->
//     KBDR stays 16'h0041, KBSR=16'hC000. Rd_KBDR -> KBSR=16'h0000.
//  5. Ready=1. Rd_KBDR is pulsed on exactly the capture edge of a new press with
//     Switches=16'h0043 -> KBDR=16'h0043, KBSR=16'h8000.
//  6. Reset_n=0 for one edge at DEB_PRS cnt=3 while the key is held -> KBSR=0. The held key
//     then captures after a full DEBOUNCE_CYCLES+3 edges from reset release.

Source files
------------

// File: rtl/kbd_input_ctrl.sv
// Keyboard front end: synchronizes and debounces the Enter key and captures the
// switch value into KBDR on each confirmed press, with a ready/overrun status word.
module kbd_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DATA_W          = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Key_n,
  input  logic [DATA_W-1:0] Switches,
  input  logic              Rd_KBDR,
  output logic [DATA_W-1:0] KBDR,
  output logic [15:0]       KBSR,
  output logic              Pressed
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DEB_PRS = 2'd1,
    PRESSED = 2'd2,
    DEB_REL = 2'd3
  } state_t;

  logic              r_sync1;
  logic              r_sync2;
  logic              w_key;
  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_capture;
  logic              r_pressed;
  logic [DATA_W-1:0] r_kbdr;
  logic              r_ready;
  logic              r_overrun;

  // Synchronizer resets to the released level so a held key must re-debounce.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= Key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_key     = ~r_sync2;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pressed <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_pressed <= (w_state_next == PRESSED) || (w_state_next == DEB_REL);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_key) begin
          w_state_next = DEB_PRS;
          w_cnt_next   = CNT_ONE;
        end
      end
      DEB_PRS: begin
        if (!w_key) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_next = PRESSED;
          w_cnt_next   = '0;
          w_capture    = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      PRESSED: begin
        if (!w_key) begin
          w_state_next = DEB_REL;
          w_cnt_next   = CNT_ONE;
        end
      end
      DEB_REL: begin
        if (w_key) begin
          w_state_next = PRESSED;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // A capture coinciding with a CPU read counts as a fresh character, not an overrun.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_kbdr    <= '0;
      r_ready   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_capture) begin
      if (!r_ready || Rd_KBDR) begin
        r_kbdr    <= Switches;
        r_ready   <= 1'b1;
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (Rd_KBDR) begin
      r_ready   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign KBDR    = r_kbdr;
  assign KBSR    = {r_ready, r_overrun, 14'b0};
  assign Pressed = r_pressed;

endmodule

// File: tb/tb_kbd_input_ctrl.sv
// Self-checking bench for kbd_input_ctrl: directed scenarios plus random key/read
// traffic, all compared each cycle against a run-length reference model.
module tb_kbd_input_ctrl;

  localparam int N = 4;

  logic        Clk;
  logic        Reset_n;
  logic        Key_n;
  logic [15:0] Switches;
  logic        Rd_KBDR;
  logic [15:0] KBDR;
  logic [15:0] KBSR;
  logic        Pressed;

  int n_vec;
  int n_err;

  kbd_input_ctrl #(.DEBOUNCE_CYCLES(N), .DATA_W(16)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Key_n    (Key_n),
    .Switches (Switches),
    .Rd_KBDR  (Rd_KBDR),
    .KBDR     (KBDR),
    .KBSR     (KBSR),
    .Pressed  (Pressed)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Reference model: raw key samples delayed two edges, level flips after
  // N+1 consecutive edges disagreeing with the current debounced level.
  bit          m_pipe[$];
  bit          m_level;
  int          m_run;
  logic [15:0] m_kbdr;
  bit          m_ready;
  bit          m_ovr;

  task automatic model_reset();
    m_pipe  = '{1'b1, 1'b1};
    m_level = 1'b0;
    m_run   = 0;
    m_kbdr  = 16'h0000;
    m_ready = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_edge();
    bit key_now;
    bit cap;
    if (!Reset_n) begin
      model_reset();
      return;
    end
    key_now = ~m_pipe[0];
    void'(m_pipe.pop_front());
    m_pipe.push_back(Key_n);
    cap = 1'b0;
    if (key_now == m_level) m_run = 0;
    else begin
      m_run++;
      if (m_run == N + 1) begin
        m_level = key_now;
        m_run   = 0;
        cap     = key_now;
      end
    end
    if (cap) begin
      if (!m_ready || Rd_KBDR) begin
        m_kbdr  = Switches;
        m_ready = 1'b1;
        m_ovr   = 1'b0;
      end else m_ovr = 1'b1;
    end else if (Rd_KBDR) begin
      m_ready = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    check("kbdr", {16'h0, KBDR}, {16'h0, m_kbdr});
    check("kbsr", {16'h0, KBSR}, {16'h0, m_ready, m_ovr, 14'b0});
    check("pressed", {31'h0, Pressed}, {31'h0, m_level});
  endtask

  task automatic press(input logic [15:0] sw, input bit rd_on_capture);
    Switches = sw;
    Key_n    = 1'b0;
    repeat (N + 2) step();
    Rd_KBDR = rd_on_capture;
    step();
    Rd_KBDR = 1'b0;
    $display("press sw=%h rd=%0d -> kbdr=%h kbsr=%h", sw, rd_on_capture, KBDR, KBSR);
  endtask

  task automatic release_key();
    Key_n = 1'b1;
    repeat (N + 4) step();
  endtask

  task automatic cpu_read();
    Rd_KBDR = 1'b1;
    step();
    Rd_KBDR = 1'b0;
    $display("read -> kbdr=%h kbsr=%h", KBDR, KBSR);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    Reset_n  = 1'b0;
    Key_n    = 1'b1;
    Switches = 16'h0000;
    Rd_KBDR  = 1'b0;
    model_reset();

    // Reset state
    repeat (2) step();
    check("rst_kbdr", {16'h0, KBDR}, 32'h0);
    check("rst_kbsr", {16'h0, KBSR}, 32'h0);
    check("rst_pressed", {31'h0, Pressed}, 32'h0);
    Reset_n = 1'b1;
    step();

    // Capture latency: visible after the 7th edge, not the 6th
    Switches = 16'h0041;
    Key_n    = 1'b0;
    repeat (N + 2) step();
    check("t2_early_kbsr", {16'h0, KBSR}, 32'h0);
    step();
    check("t2_kbsr", {16'h0, KBSR}, 32'h8000);
    check("t2_kbdr", {16'h0, KBDR}, 32'h0041);
    release_key();
    cpu_read();
    check("t2_read_kbsr", {16'h0, KBSR}, 32'h0);

    // Bouncing key never captures
    for (int r = 0; r < 5; r++) begin
      Key_n = 1'b0;
      repeat (3) step();
      Key_n = 1'b1;
      step();
    end
    repeat (8) step();
    check("t3_kbsr", {16'h0, KBSR}, 32'h0);
    check("t3_pressed", {31'h0, Pressed}, 32'h0);

    // Overrun: second press without a read is dropped
    press(16'h0041, 1'b0);
    release_key();
    press(16'h0042, 1'b0);
    check("t4_kbdr", {16'h0, KBDR}, 32'h0041);
    check("t4_kbsr", {16'h0, KBSR}, 32'hC000);
    release_key();
    cpu_read();
    check("t4_read_kbsr", {16'h0, KBSR}, 32'h0);

    // Read on the capture edge: capture wins
    press(16'h0041, 1'b0);
    release_key();
    press(16'h0043, 1'b1);
    check("t5_kbdr", {16'h0, KBDR}, 32'h0043);
    check("t5_kbsr", {16'h0, KBSR}, 32'h8000);
    release_key();
    cpu_read();

    // Reset mid-debounce with the key held, then full re-debounce
    Switches = 16'h1234;
    Key_n    = 1'b0;
    repeat (N + 1) step();
    Reset_n = 1'b0;
    step();
    check("t6_rst_kbsr", {16'h0, KBSR}, 32'h0);
    check("t6_rst_kbdr", {16'h0, KBDR}, 32'h0);
    Reset_n = 1'b1;
    repeat (N + 2) step();
    check("t6_early_kbsr", {16'h0, KBSR}, 32'h0);
    step();
    check("t6_kbsr", {16'h0, KBSR}, 32'h8000);
    check("t6_kbdr", {16'h0, KBDR}, 32'h1234);
    release_key();
    cpu_read();

    // Random key runs, switch values, reads and occasional resets
    begin
      int run_left;
      run_left = 0;
      for (int i = 0; i < 3000; i++) begin
        if (run_left == 0) begin
          Key_n    = 1'($urandom_range(0, 1));
          run_left = int'($urandom_range(1, 9));
        end
        run_left--;
        Switches = 16'($urandom);
        Rd_KBDR  = ($urandom_range(0, 5) == 0);
        Reset_n  = ($urandom_range(0, 399) != 0);
        step();
      end
      Reset_n = 1'b1;
      Rd_KBDR = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
